// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
// Holds the FSM state encoding, the 2-bit command codes carried in the top
// bits of every MOSI frame, and the default frame/reply widths.
package spi_pkg;

  localparam int SPI_RX_W = 10;
  localparam int SPI_TX_W = 8;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    WAIT_TX = 2'd2,
    SEND    = 2'd3
  } spi_slv_state_e;

  // True when a received command field matches the code that asks for a reply.
  function automatic logic cmd_wants_reply(input logic [1:0] cmd, input logic [1:0] rd_code);
    return (cmd == rd_code);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Single-bit synchroniser with edge detection.
// A SYNC_STAGES-deep flop chain brings an asynchronous pin into the clk
// domain; a further flop holds the previous synced value so rise/fall are
// one-clk strobes.  RST_VAL is the pin's idle level, so no spurious edge is
// seen when reset releases.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   prev_p;

  // Metastability chain: shift the raw pin through SYNC_STAGES flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], din};
    end
  end

  // One-clk-delayed copy of the synced level for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_p <= RST_VAL;
    end else begin
      prev_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign dout = sync_p[SYNC_STAGES-1];
  assign rise = dout & ~prev_p;
  assign fall = ~dout & prev_p;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI slave endpoint (mode 0, MSB first).
// Oversamples sclk/MOSI/ss_n in the clk domain, deserialises RX_W-bit
// command frames into rx_data and, for the read-data command, shifts one
// TX_W-bit reply byte back out on MISO.  clk must run at least 4x sclk.
// Optional build macro SPI_SLAVE_FRAME_ERR_EN adds the frame_err output,
// which pulses when a frame or reply is cut short by ss_n, or when the
// master clocks while the reply byte is still pending.
// Requires RX_W >= 3 and TX_W >= 3.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int         RX_W        = SPI_RX_W,
  parameter int         TX_W        = SPI_TX_W,
  parameter int         SYNC_STAGES = 2,
  parameter logic [1:0] RD_CMD      = CMD_RD_DATA
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            MOSI,
  input  logic            ss_n,
  output logic            MISO,
  output logic            valid_MISO,
  output logic            sready,
  output logic [RX_W-1:0] rx_data,
  output logic            rx_valid,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic            frame_err,
`endif
  input  logic [TX_W-1:0] tx_data,
  input  logic            tx_valid
);

  localparam int              BW       = $clog2(RX_W + 1);
  localparam int              TW       = $clog2(TX_W + 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(RX_W - 1);
  localparam logic [TW-1:0]   TX_LAST  = TW'(TX_W - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic ss_n_s, ss_n_rise, ss_n_fall;

  spi_slv_state_e   state;
  logic [BW-1:0]    bit_cnt;
  logic [TW-1:0]    tx_cnt;
  // Bits received so far; the final bit is appended straight into rx_data.
  logic [RX_W-2:0]  shreg;
  // Reply bits still to be shifted out after the MSB already on MISO.
  logic [TX_W-2:0]  tx_rest;

  // All three pins share one synchroniser depth so they stay cycle-aligned.
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst  (rst),
    .din  (sclk),
    .dout (sclk_lvl),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst  (rst),
    .din  (MOSI),
    .dout (mosi_s),
    .rise (mosi_rise),
    .fall (mosi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .din  (ss_n),
    .dout (ss_n_s),
    .rise (ss_n_rise),
    .fall (ss_n_fall)
  );

  // Edge strobes on MOSI/ss_n-rise and the raw sclk level are not needed.
  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, mosi_rise, mosi_fall, ss_n_rise};

  // Control FSM with all outputs registered; ss_n deassert aborts any
  // transfer in progress and takes priority over same-cycle sclk edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tx_cnt     <= '0;
      shreg      <= '0;
      tx_rest    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      MISO       <= 1'b0;
      valid_MISO <= 1'b0;
      sready     <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          sready <= ss_n_s;
          if (ss_n_fall) begin
            state   <= RECV;
            bit_cnt <= '0;
            shreg   <= '0;
            sready  <= 1'b0;
          end
        end

        RECV: begin
          if (ss_n_s) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            MISO       <= 1'b0;
            valid_MISO <= 1'b0;
            sready     <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err  <= 1'b1;
`endif
          end else if (sclk_rise) begin
            if (bit_cnt == BIT_LAST) begin
              rx_data  <= {shreg, mosi_s};
              rx_valid <= 1'b1;
              bit_cnt  <= '0;
              if (cmd_wants_reply(shreg[RX_W-2 -: 2], RD_CMD)) begin
                state <= WAIT_TX;
              end else begin
                state <= IDLE;
              end
            end else begin
              shreg   <= {shreg[RX_W-3:0], mosi_s};
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end

        WAIT_TX: begin
          if (ss_n_s) begin
            state      <= IDLE;
            MISO       <= 1'b0;
            valid_MISO <= 1'b0;
            sready     <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err  <= 1'b1;
`endif
          end else begin
            if (tx_valid) begin
              tx_rest    <= tx_data[TX_W-2:0];
              MISO       <= tx_data[TX_W-1];
              valid_MISO <= 1'b1;
              tx_cnt     <= '0;
              state      <= SEND;
            end
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (sclk_rise) begin
              frame_err <= 1'b1;
            end
`endif
          end
        end

        SEND: begin
          if (ss_n_s) begin
            state      <= IDLE;
            tx_cnt     <= '0;
            MISO       <= 1'b0;
            valid_MISO <= 1'b0;
            sready     <= 1'b1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err  <= 1'b1;
`endif
          end else if (sclk_rise) begin
            if (tx_cnt == TX_LAST) begin
              tx_cnt     <= '0;
              MISO       <= 1'b0;
              valid_MISO <= 1'b0;
              state      <= IDLE;
            end else begin
              tx_cnt <= tx_cnt + TW'(1);
            end
          end else if (sclk_fall && (tx_cnt != '0)) begin
            // A fall before the first rise is the tail of the command frame.
            MISO    <= tx_rest[TX_W-2];
            tx_rest <= {tx_rest[TX_W-3:0], 1'b0};
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Bench for spi_slave_rx_tx: plays the SPI master at clk = 8x sclk, logs
// every rx_valid pulse, and compares frames and reply bytes against a
// simple transaction-level expectation (frame in == rx_data out, reply
// byte == tx_data MSB first when the command is 2'b11).
module tb_spi_slave_rx_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       MOSI = 1'b0;
  logic       ss_n = 1'b1;
  logic       MISO;
  logic       valid_MISO;
  logic       sready;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
  int         fe_cnt = 0;
`endif

  int         errors = 0;
  int         checks = 0;
  logic [9:0] rx_log[$];
  int         vm_cnt = 0;

  spi_slave_rx_tx dut (
    .clk        (clk),
    .rst        (rst),
    .sclk       (sclk),
    .MOSI       (MOSI),
    .ss_n       (ss_n),
    .MISO       (MISO),
    .valid_MISO (valid_MISO),
    .sready     (sready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
`ifdef SPI_SLAVE_FRAME_ERR_EN
    .frame_err  (frame_err),
`endif
    .tx_data    (tx_data),
    .tx_valid   (tx_valid)
  );

  always #5 clk = ~clk;

  // Observe outputs away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) rx_log.push_back(rx_data);
    if (valid_MISO) vm_cnt <= vm_cnt + 1;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    if (frame_err) fe_cnt <= fe_cnt + 1;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master: select the slave and clock out nbits of f, MSB first.
  task automatic send_frame(input logic [9:0] f, input int nbits);
    ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      MOSI = f[9-i];
      tick(4);
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
    tick(2);
  endtask

  // Master: clock n reply bits, sampling MISO just before each rise.
  task automatic read_reply(input int n, output logic [7:0] bits, output logic vm_ok);
    bits  = 8'h00;
    vm_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(4);
      bits[7-i] = MISO;
      if (valid_MISO !== 1'b1) vm_ok = 1'b0;
      sclk = 1'b1;
      tick(4);
      sclk = 1'b0;
    end
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    MOSI = 1'b0;
    tick(6);
  endtask

  task automatic give_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(2);
  endtask

  initial begin
    logic [9:0] last_frame;
    logic [9:0] f;
    logic [7:0] tb;
    logic [7:0] got;
    logic       vm_ok;
    int         base;
    int         vm0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    int         fe0;
`endif
    last_frame = 10'h000;

    // Reset state
    tick(2);
    chk("rst_MISO", 32'(MISO), 32'd0);
    chk("rst_valid_MISO", 32'(valid_MISO), 32'd0);
    chk("rst_sready", 32'(sready), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    rst = 1'b0;
    tick(2);
    chk("post_rst_sready", 32'(sready), 32'd1);

    // Write frame, no reply expected
    base = rx_log.size();
    vm0  = vm_cnt;
    send_frame(10'b00_1010_0101, 10);
    tick(4);
    end_frame();
    chk("wr_pulses", 32'(rx_log.size() - base), 32'd1);
    if (rx_log.size() > base) chk("wr_log_data", 32'(rx_log[base]), 32'h0A5);
    chk("wr_rx_data", 32'(rx_data), 32'h0A5);
    chk("wr_no_reply", 32'(vm_cnt - vm0), 32'd0);
    chk("wr_sready", 32'(sready), 32'd1);
    last_frame = 10'h0A5;

    // Read-data frame with reply 0xC3
    base = rx_log.size();
    send_frame(10'b11_0000_0000, 10);
    give_tx(8'hC3);
    chk("rd_vm_start", 32'(valid_MISO), 32'd1);
    chk("rd_miso_msb", 32'(MISO), 32'd1);
    read_reply(8, got, vm_ok);
    chk("rd_reply", 32'(got), 32'hC3);
    chk("rd_vm_held", 32'(vm_ok), 32'd1);
    tick(2);
    chk("rd_vm_end", 32'(valid_MISO), 32'd0);
    chk("rd_miso_end", 32'(MISO), 32'd0);
    end_frame();
    chk("rd_pulses", 32'(rx_log.size() - base), 32'd1);
    chk("rd_rx_data", 32'(rx_data), 32'h300);
    last_frame = 10'h300;

    // Randomised frames: reply iff command is 2'b11
    for (int k = 0; k < 8; k++) begin
      f  = 10'($urandom_range(0, 1023));
      if (k % 2 == 1) f[9:8] = 2'b11;
      tb = 8'($urandom_range(0, 255));
      base = rx_log.size();
      vm0  = vm_cnt;
      send_frame(f, 10);
      if (f[9:8] == 2'b11) begin
        give_tx(tb);
        read_reply(8, got, vm_ok);
        chk("rnd_reply", 32'(got), 32'(tb));
        chk("rnd_vm_held", 32'(vm_ok), 32'd1);
        tick(2);
        chk("rnd_vm_end", 32'(valid_MISO), 32'd0);
      end else begin
        tick(4);
        chk("rnd_no_reply", 32'(vm_cnt - vm0), 32'd0);
      end
      end_frame();
      chk("rnd_pulses", 32'(rx_log.size() - base), 32'd1);
      chk("rnd_rx_data", 32'(rx_data), 32'(f));
      last_frame = f;
    end

    // tx_valid while idle must not start a reply
    vm0 = vm_cnt;
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    tick(3);
    chk("idle_txv_ignored", 32'(vm_cnt - vm0), 32'd0);

    // Aborted frame after 5 bits
    base = rx_log.size();
    send_frame(10'h3FF, 5);
    ss_n = 1'b1;
    tick(4);
    chk("abort_sready", 32'(sready), 32'd1);
    tick(4);
    chk("abort_no_pulse", 32'(rx_log.size() - base), 32'd0);
    chk("abort_rx_held", 32'(rx_data), 32'(last_frame));

    // Reset in the middle of a reply
    send_frame(10'h3C1, 10);
    give_tx(8'hFF);
    read_reply(3, got, vm_ok);
    chk("midsend_vm", 32'(valid_MISO), 32'd1);
    rst = 1'b1;
    #1;
    chk("midsend_rst_MISO", 32'(MISO), 32'd0);
    chk("midsend_rst_vm", 32'(valid_MISO), 32'd0);
    chk("midsend_rst_rx", 32'(rx_data), 32'd0);
    sclk = 1'b0;
    ss_n = 1'b1;
    MOSI = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("midsend_sready", 32'(sready), 32'd1);
    base = rx_log.size();
    send_frame(10'h15A, 10);
    end_frame();
    chk("after_rst_pulses", 32'(rx_log.size() - base), 32'd1);
    chk("after_rst_data", 32'(rx_data), 32'h15A);

    // Back-to-back frames with a short ss_n gap
    base = rx_log.size();
    send_frame(10'h155, 10);
    ss_n = 1'b1;
    tick(2);
    send_frame(10'h2AA, 10);
    end_frame();
    chk("b2b_pulses", 32'(rx_log.size() - base), 32'd2);
    if (rx_log.size() >= base + 2) begin
      chk("b2b_first", 32'(rx_log[base]), 32'h155);
      chk("b2b_second", 32'(rx_log[base+1]), 32'h2AA);
    end

    // Master clocks during WAIT_TX, then drops ss_n
    vm0 = vm_cnt;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    fe0 = fe_cnt;
`endif
    send_frame(10'h3F0, 10);
    sclk = 1'b1;
    tick(4);
    sclk = 1'b0;
    tick(4);
    end_frame();
    chk("waittx_sready", 32'(sready), 32'd1);
    chk("waittx_no_reply", 32'(vm_cnt - vm0), 32'd0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("frame_err_pulses", 32'(fe_cnt - fe0), 32'd2);
`endif
    base = rx_log.size();
    send_frame(10'h0FF, 10);
    end_frame();
    chk("recover_pulses", 32'(rx_log.size() - base), 32'd1);
    chk("recover_data", 32'(rx_data), 32'h0FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
